fetch_unit: RTL and testbench
=============================

# fetch_unit

- Fetch stage of the five-stage MIPS pipeline: holds `PC_F`, issues instruction-memory requests over a req/ack handshake, and fills the IF/ID register.
- It is the consuming end of the next-PC path. It takes the D-stage redirect (`npc_sel`, `NPC`) and applies it with one architectural delay slot.
- It absorbs memory wait states with bubbles and D-stage stalls with a one-entry hold buffer.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall_D`  in  1  hazard unit: IF/ID and the fetch state hold when high.
- `npc_sel`  in  1  D-stage instruction is j/jal/taken beq. The block gates it with `valid_D & ~stall_D`.
- `NPC`  in  32  redirect target computed in D.
- `im_req`  out  1  instruction fetch request.
- `im_addr`  out  32  fetch address, equal to `PC_F`.
- `im_ack`  in  1  memory returns `im_rdata` this cycle. It may be asserted in the same cycle as `im_req`.
- `im_rdata`  in  32  instruction word; sampled only when `im_req & im_ack`.
- `PC_F`  out  32  current fetch PC.
- `IR_D`, `PC_D`, `PC4_D`  out  32 each  IF/ID register contents.
- `valid_D`  out  1  IF/ID holds a real instruction. When low, `IR_D` is 0 (nop).
- `adel_D`  out  1  misaligned-fetch flag. Present only with `PC_ALIGN_CHK_EN`.

## Operation
- States:
  - RUN: request outstanding.
  - HOLD: fetched word buffered while D is stalled.
  - ERR: only with the macro.
- `im_req` is 1 in RUN and 0 otherwise.
- RUN, `im_ack=1`, `stall_D=0` (delivery):
  - IF/ID <= {`im_rdata`, `PC_F`, `PC_F+4`}; `valid_D` <= 1.
  - `PC_F` <= next PC.
- RUN, `im_ack=1`, `stall_D=1`:
  - buffer <= `im_rdata`; go to HOLD.
  - `PC_F` and IF/ID hold.
- RUN, `im_ack=0`:
  - if `stall_D=0`: inject bubble (`IR_D`=0, `valid_D`=0, `PC_D`<=`PC_F`, `PC4_D`<=`PC_F+4`).
  - if `stall_D=1`: IF/ID holds.
- HOLD, `stall_D=0` (delivery): IF/ID <= {buffer, `PC_F`, `PC_F+4`}, `valid_D` <= 1, `PC_F` <= next PC, go to RUN.
- HOLD, `stall_D=1`: everything holds.
- Next PC, priority order:
  1. `NPC` when the gated `npc_sel` is high in the same cycle as a delivery.
  2. `redir_pc` when `redir_pend` is set.
  3. Otherwise `PC_F+4`.
- Delay slot: the word delivered in the same cycle as the redirect, or the first word delivered after it, is the delay slot and is never squashed.
- Gated `npc_sel` without a delivery (D has left, bubble injected): latch `redir_pend`=1 and `redir_pc`=`NPC`. The next delivery consumes and clears it.
- Gated `npc_sel` while `redir_pend` is already set cannot occur, because a bubble in D has `valid_D`=0.
- All PC arithmetic is 32-bit modulo 2^32; `PC_F+4` wraps from FFFF_FFFC to 0000_0000.

## Timing
- Reset values, applied asynchronously while `reset_n`=0:
  - `PC_F`=`RESET_PC`.
  - `IR_D`=0, `PC_D`=0, `PC4_D`=0, `valid_D`=0, `adel_D`=0.
  - `redir_pend`=0, state=RUN.
  - `im_req`=0 while reset is asserted; `im_req`=1 from the first edge after release.
- Reset mid-request abandons the outstanding fetch. The memory shares `reset_n` and drops it as well.
- Throughput: one instruction per cycle with a zero-wait ack. Each wait cycle inserts exactly one bubble if D is not stalled.
- `im_addr` is stable from request until ack. It changes only on the edge after an ack (RUN delivery) or on HOLD exit.
- Stall priority: `stall_D` overrides everything, including a pending redirect. No PC or IF/ID change happens while it is high, except the RUN -> HOLD buffering.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - A RUN cycle with `PC_F[1:0]`!=0 issues no request (`im_req`=0).
  - When `stall_D`=0, the block delivers `IR_D`=0, `valid_D`=1, `adel_D`=1, `PC_D`=`PC_F`, then enters ERR.
  - ERR holds all state and keeps `im_req`=0 until reset.
  - `adel_D` is 0 on every other delivery.
- Not defined:
  - `PC_F[1:0]` is forced to 00 on every load, including reset and redirect.
  - No `adel_D` port, no ERR state.

## Test plan
- Reset release, memory always acks: `im_addr` = 3000, 3004, 3008 on consecutive cycles. `IR_D`/`PC_D` follow one cycle later with `valid_D`=1.
- Two-cycle wait on fetch of 3004, no stall: exactly two bubbles (`valid_D`=0, `IR_D`=0), then `PC_D`=3004.
- j at 3000 with target 3100: `PC_D` sequence 3000, 3004 (delay slot), 3100.
- Same j, but the delay-slot fetch at 3004 has a one-cycle wait: one bubble, then 3004, then 3100 (`redir_pend` path).
- Ack for 3008 arrives while `stall_D`=1 for 3 cycles: HOLD, `im_req`=0, IF/ID frozen. After the stall drops, `PC_D`=3008 with the buffered word; no re-fetch.
- With `PC_ALIGN_CHK_EN`, beq in D redirects to 3102: after the delay slot, one delivery with `adel_D`=1, `PC_D`=3102; `im_req` stays 0 until `reset_n` pulses low.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- IF stage of the five-stage MIPS pipeline.
//
// Holds PC_F and issues instruction-memory requests over a req/ack
// handshake. Returned words are written into the IF/ID register.
//
// Memory wait states, D-stage stalls and redirects are handled as follows:
//   - A wait cycle with D not stalled inserts one bubble (valid_D=0, IR_D=0).
//   - A word that is acked while D is stalled is parked in a one-entry hold
//     buffer. It is delivered later without a second fetch.
//   - A D-stage redirect (npc_sel/NPC) is applied with one delay slot. The
//     delay slot is the word delivered in the same cycle as the redirect, or
//     the first word delivered after it.
//
// Optional feature, selected by the macro PC_ALIGN_CHK_EN:
//   - A misaligned PC_F issues no request.
//   - The block delivers a single adel_D marker and then parks in ERR until
//     reset.
//   - Without the macro, PC_F[1:0] is forced to 00 on every load and the
//     adel_D port does not exist.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   stall_D    hazard-unit stall; freezes PC_F and IF/ID
//   npc_sel    D-stage redirect request (gated with valid_D & ~stall_D)
//   NPC        redirect target
//   im_req     fetch request
//   im_addr    fetch address (== PC_F)
//   im_ack     memory returns im_rdata this cycle
//   im_rdata   instruction word
//   PC_F       current fetch PC
//   IR_D       IF/ID instruction word (0 when not valid)
//   PC_D       IF/ID PC
//   PC4_D      IF/ID PC + 4
//   valid_D    IF/ID holds a real instruction
//   adel_D     misaligned-fetch marker (only with PC_ALIGN_CHK_EN)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_D,
  input  logic        npc_sel,
  input  logic [31:0] NPC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic        adel_D
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Low for the first cycle after reset release, so that no request is
  // visible while reset_n is asserted.
  logic        r_live;

  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_ir;
  logic [31:0] r_pcd;
  logic [31:0] r_pc4d;
  logic        r_vld;
  logic        r_adel;
  logic        r_redir_pend;
  logic [31:0] r_redir_pc;

  logic [31:0] w_pc4;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_ld;
  logic        w_misal;
  logic        w_run;
  logic        w_req;
  logic        w_ack;
  logic        w_dlv_mem;
  logic        w_dlv_buf;
  logic        w_dlv;
  logic        w_bubble;
  logic        w_adel;
  logic        w_sel;

`ifdef PC_ALIGN_CHK_EN
  localparam logic [31:0] RESET_PC_EFF = RESET_PC;
  assign w_misal = |r_pc[1:0];
`else
  localparam logic [31:0] RESET_PC_EFF = RESET_PC & ~32'd3;
  assign w_misal = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Cycle classification
  // ---------------------------------------------------------------------
  assign w_pc4     = r_pc + 32'd4;
  assign w_run     = r_live & (r_state == ST_RUN);
  assign w_req     = w_run & ~w_misal;
  assign w_ack     = w_req & im_ack;
  assign w_dlv_mem = w_ack & ~stall_D;
  assign w_dlv_buf = (r_state == ST_HOLD) & ~stall_D;
  assign w_dlv     = w_dlv_mem | w_dlv_buf;
  assign w_bubble  = w_req & ~im_ack & ~stall_D;
  assign w_adel    = w_run & w_misal & ~stall_D;
  assign w_sel     = npc_sel & r_vld & ~stall_D;

  // A redirect coinciding with a delivery wins. A redirect latched earlier
  // (while D was taking a bubble) is used next. Otherwise fall through.
  assign w_pc_nxt = w_sel        ? NPC        :
                    r_redir_pend ? r_redir_pc :
                                   w_pc4;

`ifdef PC_ALIGN_CHK_EN
  assign w_pc_ld = w_pc_nxt;
`else
  assign w_pc_ld = w_pc_nxt & ~32'd3;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_ack && stall_D) w_state_nxt = ST_HOLD;
`ifdef PC_ALIGN_CHK_EN
        else if (w_adel)      w_state_nxt = ST_ERR;
`endif
      end
      ST_HOLD: if (!stall_D) w_state_nxt = ST_RUN;
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    im_req = w_req;
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_pc <= RESET_PC_EFF;
    else if (w_dlv) r_pc <= w_pc_ld;
  end

  // The hold buffer only captures a word that D could not take.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_buf <= '0;
    else if (w_ack && stall_D) r_buf <= im_rdata;
  end

  // A redirect seen while D is taking a bubble has no delivery to steer,
  // so it is parked until the next delivery, which consumes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redir_pend <= 1'b0;
      r_redir_pc   <= '0;
    end else if (w_dlv) begin
      r_redir_pend <= 1'b0;
    end else if (w_sel && w_bubble) begin
      r_redir_pend <= 1'b1;
      r_redir_pc   <= NPC;
    end
  end

  // IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir   <= '0;
      r_pcd  <= '0;
      r_pc4d <= '0;
      r_vld  <= 1'b0;
      r_adel <= 1'b0;
    end else if (w_dlv) begin
      r_ir   <= w_dlv_mem ? im_rdata : r_buf;
      r_pcd  <= r_pc;
      r_pc4d <= w_pc4;
      r_vld  <= 1'b1;
      r_adel <= 1'b0;
    end else if (w_bubble) begin
      r_ir   <= '0;
      r_pcd  <= r_pc;
      r_pc4d <= w_pc4;
      r_vld  <= 1'b0;
      r_adel <= 1'b0;
    end else if (w_adel) begin
      // Marker instruction for the exception logic downstream.
      r_ir   <= '0;
      r_pcd  <= r_pc;
      r_pc4d <= w_pc4;
      r_vld  <= 1'b1;
      r_adel <= 1'b1;
    end
  end

  assign im_addr = r_pc;
  assign PC_F    = r_pc;
  assign IR_D    = r_ir;
  assign PC_D    = r_pcd;
  assign PC4_D   = r_pc4d;
  assign valid_D = r_vld;

`ifdef PC_ALIGN_CHK_EN
  assign adel_D = r_adel;
`else
  // The marker register only ever loads 0 in this build. It is kept so
  // that the IF/ID update stays identical across both builds.
  logic w_adel_unused;
  assign w_adel_unused = r_adel;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized bench for fetch_unit.
//
// The reference model works at the level of the architectural instruction
// stream. It tracks the PC expected at the next delivered instruction:
//   - normally PC+4;
//   - after a taken redirect, one delay slot and then the target.
// Memory is a pure function of the address, so every delivered IR_D is
// checked against mem(PC_D).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_D = 1'b0;
  logic        npc_sel = 1'b0;
  logic [31:0] NPC = '0;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] PC_F;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] PC4_D;
  logic        valid_D;
`ifdef PC_ALIGN_CHK_EN
  logic        adel_D;
`endif

  int n_chk = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset_n(reset_n), .stall_D(stall_D), .npc_sel(npc_sel),
    .NPC(NPC), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .PC_F(PC_F), .IR_D(IR_D), .PC_D(PC_D),
    .PC4_D(PC4_D), .valid_D(valid_D)
`ifdef PC_ALIGN_CHK_EN
    , .adel_D(adel_D)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else                           t = 32'h0000_3000 + ($urandom & 32'hFFF);
`ifdef PC_ALIGN_CHK_EN
    t = t & ~32'd3;
`endif
    return t;
  endfunction

  initial begin
    logic [31:0] exp_pc, tgt, p_addr, p_ir, p_pcd, p_pc4, p_pcf;
    logic        armed, d_slot, p_req, p_ack, p_stall, p_vld, warm;
    int          n_dlv;
    exp_pc = 32'h0000_3000;
    tgt = '0;
    armed = 1'b0;
    d_slot = 1'b0;
    n_dlv = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_f",  PC_F,    32'h0000_3000);
    chk("rst_ir_d",  IR_D,    32'h0);
    chk("rst_pc_d",  PC_D,    32'h0);
    chk("rst_pc4_d", PC4_D,   32'h0);
    chk("rst_valid", valid_D, 32'h0);
    chk("rst_req",   im_req,  32'h0);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      warm = (cyc < 5);
      stall_D  = warm ? 1'b0 : ($urandom_range(0, 3) == 0);
      im_ack   = warm ? 1'b1 : ($urandom_range(0, 9) < 7);
      im_rdata = im_ack ? mem(im_addr) : $urandom;
      if (valid_D && !stall_D && !d_slot && !warm && $urandom_range(0, 5) == 0) begin
        npc_sel = 1'b1;
        NPC     = pick_tgt();
      end else begin
        // Noise on npc_sel only where the gating must ignore it.
        npc_sel = !(valid_D && !stall_D) && ($urandom_range(0, 2) == 0);
        NPC     = $urandom;
      end

      p_req = im_req;
      p_ack = im_ack;
      p_stall = stall_D;
      p_addr = im_addr;
      p_ir = IR_D;
      p_pcd = PC_D;
      p_pc4 = PC4_D;
      p_vld = valid_D;
      p_pcf = PC_F;
      if (npc_sel && valid_D && !stall_D) begin
        armed = 1'b1;
        tgt   = NPC & ~32'd3;
      end

      @(posedge clk);
      #1;

      chk("addr_eq_pc", im_addr, PC_F);
      if (cyc < 4) begin
        chk("warm_addr", im_addr, 32'h0000_3000 + 32'(4 * cyc));
        chk("warm_req",  im_req,  32'h1);
      end
      if (p_req && !p_ack) chk("addr_stable", im_addr, p_addr);
      if (p_req && p_ack && p_stall) chk("hold_no_req", im_req, 32'h0);

      if (p_stall) begin
        chk("stall_ir",  IR_D,    p_ir);
        chk("stall_pcd", PC_D,    p_pcd);
        chk("stall_pc4", PC4_D,   p_pc4);
        chk("stall_vld", valid_D, p_vld);
        chk("stall_pcf", PC_F,    p_pcf);
      end else if (valid_D) begin
        n_dlv++;
        chk("dlv_pc_d",  PC_D,  exp_pc);
        chk("dlv_ir_d",  IR_D,  mem(exp_pc));
        chk("dlv_pc4_d", PC4_D, exp_pc + 32'd4);
`ifdef PC_ALIGN_CHK_EN
        chk("dlv_adel",  adel_D, 32'h0);
`endif
        if (armed) begin
          d_slot = 1'b1;
          armed  = 1'b0;
          exp_pc = tgt;
        end else begin
          d_slot = 1'b0;
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        chk("bubble_ir", IR_D, 32'h0);
      end
    end
    chk("progress", 32'(n_dlv > 500), 32'h1);

`ifdef PC_ALIGN_CHK_EN
    // Redirect to a misaligned target: delay slot, then one adel marker,
    // then ERR until reset.
    stall_D = 1'b0;
    npc_sel = 1'b0;
    im_ack  = 1'b1;
    reset_n = 1'b0;
    #20;
    reset_n = 1'b1;
    @(posedge clk); #1;
    im_rdata = mem(im_addr);
    @(posedge clk); #1;
    chk("err_pre_pcd", PC_D, 32'h0000_3000);
    npc_sel  = 1'b1;
    NPC      = 32'h0000_3102;
    im_rdata = mem(im_addr);
    @(posedge clk); #1;
    npc_sel = 1'b0;
    chk("err_slot_pcd", PC_D,   32'h0000_3004);
    chk("err_misal_req", im_req, 32'h0);
    @(posedge clk); #1;
    chk("err_adel",  adel_D,  32'h1);
    chk("err_pcd",   PC_D,    32'h0000_3102);
    chk("err_ir",    IR_D,    32'h0);
    chk("err_valid", valid_D, 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("err_req_low", im_req, 32'h0);
      chk("err_pcf",     PC_F,   32'h0000_3102);
    end
    reset_n = 1'b0;
    #1;
    chk("err_rst_adel", adel_D, 32'h0);
    chk("err_rst_req",  im_req, 32'h0);
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("err_rel_req",  im_req,  32'h1);
    chk("err_rel_addr", im_addr, 32'h0000_3000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
